sd_otf_converter: RTL
=====================

// Module: sd_otf_converter
// PURPOSE
//  Downstream stage of the radix-2 online divider. Consumes the MSD-first signed-digit
//  quotient stream (q_value) and builds the conventional two's-complement quotient by
//  on-the-fly conversion (Q/QM registers), so no carry-propagate adder is needed.
//  Discards the first ONLINE_DELAY digits of each stream (divider start-up latency).
//  Presents the N_DIGITS-digit result in parallel with a one-cycle valid pulse.
// PARAMETERS
//  N_DIGITS      64  quotient digits per operation (matches divider unrolling)
//  ONLINE_DELAY  3   leading stream digits discarded per operation (0 allowed)
//  OUT_W         N_DIGITS+1  localparam: result width, 1 sign/int bit + N_DIGITS frac bits
//  CNT_W         $clog2(ONLINE_DELAY+N_DIGITS+1)  localparam: digit counter width
// PORTS
//  clk           in   1      rising-edge clock
//  asyn_reset    in   1      asynchronous, active-low reset
//  enable_all    in   1      digit qualifier; q_value consumed only when 1 (same signal as divider)
//  q_value       in   2      signed digit {plus,minus}: 10=+1, 01=-1, 00=0, 11=illegal
//  result        out  OUT_W  two's-complement quotient, LSB weight 2^-N_DIGITS
//  result_valid  out  1      one-cycle pulse: result updated this cycle
//  busy          out  1      1 while in SKIP or CONV
//  digit_err     out  1      1 if any illegal digit seen in CONV of the last completed op
// BEHAVIOUR
//  Reset (asyn_reset=0, async): state=IDLE, idx=0, Q=0, QM=all-ones, result=0,
//   result_valid=0, busy=0, digit_err=0, err_sticky=0.
//  Accepted digit = cycle with enable_all=1; idx counts accepted digits of current op
//   (0..ONLINE_DELAY+N_DIGITS-1). Cycles with enable_all=0: all state held, q_value ignored.
//  FSM: IDLE -> on accepted digit: idx=0 is stream start; Q=0, QM=-1, err_sticky=0;
//   if ONLINE_DELAY>0 digit discarded, go SKIP (or CONV if ONLINE_DELAY=1);
//   if ONLINE_DELAY=0 digit processed as q_1, go CONV.
//   SKIP: discard digits until idx=ONLINE_DELAY-1 accepted, then CONV.
//   CONV: each accepted digit updates Q/QM; after digit idx=ONLINE_DELAY+N_DIGITS-1 -> IDLE.
//  OTF update (registers OUT_W wide, shift left, top bit dropped):
//   +1: Q<={Q,1}  QM<={Q,0};  0: Q<={Q,0}  QM<={QM,1};  -1: Q<={QM,1}  QM<={QM,0}.
//   Illegal 11: treated as 0, sets err_sticky.
//  Completion: on the last CONV digit, result<=next Q, digit_err<=next err_sticky,
//   result_valid=1 on the following cycle only; result/digit_err hold until next completion.
//  Latency: result_valid one cycle after the (ONLINE_DELAY+N_DIGITS)-th accepted digit.
//  Back-to-back: accepted digit in the IDLE cycle right after completion starts the next op;
//   no bubble required; previous result remains visible meanwhile.
//  Range: |value| <= 1-2^-N_DIGITS, always fits OUT_W; no overflow handling.
//  busy=1 in SKIP/CONV; 0 in IDLE (incl. the cycle of result_valid).
//  Reset mid-operation: abort to reset values; no result_valid for the aborted op.
// STRUCTURE
//  Shared include online_sd_defs.vh: digit codes SD_POS=2'b10, SD_NEG=2'b01, SD_ZERO=2'b00,
//   FSM state codes IDLE/SKIP/CONV. Reused by divider-side blocks.
//  Sub-module otf_qqm_reg (param W): Q/QM registers, init/shift-enable inputs, update rule.
//  Top: FSM, idx counter, err_sticky, result/valid registers.
// TESTING (bench override N_DIGITS=4, ONLINE_DELAY=3 unless stated)
//  Reset: asyn_reset=0 any time -> result=0, result_valid=0, busy=0, digit_err=0 immediately.
//  Stream +1,+1,+1 (discarded), then +1,0,-1,+1 -> result=5'b00111 (7/16), valid 1 cycle after 7th digit.
//  Skip digits 0, then -1,-1,-1,-1 -> result=5'b10001 (-15/16); +1 x4 -> 5'b01111.
//  Stall: as case 2 with enable_all=0 for 5 cycles mid-CONV, q_value=10 during gap -> same 5'b00111.
//  Back-to-back: enable_all=1 for 14 cycles, two streams -> two valid pulses 7 cycles apart, both correct.
//  Reset after 2 CONV digits, then fresh case-2 stream -> no pulse for aborted op, then 5'b00111;
//   digit 11 in CONV -> treated as 0, digit_err=1 with that result, cleared by next clean op.

Source files
------------

// File: rtl/sd_otf_converter_pkg.sv
// Shared definitions for the online-divider quotient path: signed-digit
// encodings, converter FSM state codes and a small digit-decode helper.
package sd_otf_converter_pkg;

  // Signed-digit encoding {plus, minus}
  localparam logic [1:0] SD_ZERO = 2'b00;
  localparam logic [1:0] SD_NEG  = 2'b01;
  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SKIP = 2'd1,
    CONV = 2'd2
  } otf_state_e;

  // Both plus and minus asserted has no meaning in the digit set {-1,0,+1}
  function automatic logic sd_is_illegal(input logic [1:0] digit);
    return (digit == SD_ILL);
  endfunction

endpackage

// File: rtl/sd_otf_converter_qqm.sv
// On-the-fly conversion register pair. Q holds the converted prefix, QM holds
// Q minus one LSB of the current prefix length, so appending a -1 digit is a
// select-and-shift instead of a borrow-propagating subtraction.
module otf_qqm_reg
  import sd_otf_converter_pkg::*;
#(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         asyn_reset,
  input  logic         init,
  input  logic         shift,
  input  logic [1:0]   digit,
  output logic [W-1:0] q_next
);

  logic [W-1:0] q;
  logic [W-1:0] qm;
  logic [W-1:0] q_base;
  logic [W-1:0] qm_base;
  logic [W-1:0] q_nxt;
  logic [W-1:0] qm_nxt;

  // Next Q/QM: optional re-initialisation, then the append rule for this digit.
  // Init and shift may coincide when the very first stream digit is converted.
  always_comb begin
    q_base  = init ? '0 : q;
    qm_base = init ? '1 : qm;
    q_nxt   = q_base;
    qm_nxt  = qm_base;
    if (shift) begin
      case (digit)
        SD_POS: begin
          q_nxt  = {q_base[W-2:0], 1'b1};
          qm_nxt = {q_base[W-2:0], 1'b0};
        end
        SD_NEG: begin
          q_nxt  = {qm_base[W-2:0], 1'b1};
          qm_nxt = {qm_base[W-2:0], 1'b0};
        end
        // zero, and the illegal code treated as zero
        default: begin
          q_nxt  = {q_base[W-2:0], 1'b0};
          qm_nxt = {qm_base[W-2:0], 1'b1};
        end
      endcase
    end
  end

  // Q/QM state; q_nxt equals the current value when neither init nor shift.
  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      q  <= '0;
      qm <= '1;
    end else begin
      q  <= q_nxt;
      qm <= qm_nxt;
    end
  end

  assign q_next = q_nxt;

endmodule

// File: rtl/sd_otf_converter.sv
// Signed-digit to two's-complement quotient converter for the radix-2 online
// divider. Drops the divider start-up digits, converts the remaining digits
// on the fly and presents the parallel result with a one-cycle valid pulse.
//
// state | meaning
// IDLE  | waiting for the first digit of a stream (also the completion cycle)
// SKIP  | discarding divider start-up digits
// CONV  | converting quotient digits into Q/QM
module sd_otf_converter
  import sd_otf_converter_pkg::*;
#(
  parameter  int N_DIGITS     = 64,
  parameter  int ONLINE_DELAY = 3,
  localparam int OUT_W        = N_DIGITS + 1,
  localparam int CNT_W        = $clog2(ONLINE_DELAY + N_DIGITS + 1)
) (
  input  logic             clk,
  input  logic             asyn_reset,
  input  logic             enable_all,
  input  logic [1:0]       q_value,
  output logic [OUT_W-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             digit_err
);

  localparam logic [CNT_W-1:0] OD_IDX   = CNT_W'(ONLINE_DELAY);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ONLINE_DELAY + N_DIGITS - 1);

  otf_state_e       state;
  otf_state_e       state_nxt;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] cur_idx;
  logic [CNT_W-1:0] idx_inc;
  logic             accept;
  logic             start;
  logic             conv_digit;
  logic             last_digit;
  logic             err_sticky;
  logic             err_nxt;
  logic [OUT_W-1:0] q_next;

  // Classify the current cycle's digit; in IDLE an accepted digit is index 0.
  always_comb begin
    accept     = enable_all;
    cur_idx    = (state == IDLE) ? '0 : idx;
    idx_inc    = cur_idx + CNT_W'(1);
    start      = accept && (state == IDLE);
    conv_digit = accept && (cur_idx >= OD_IDX);
    last_digit = accept && (cur_idx == LAST_IDX);
    err_nxt    = (start ? 1'b0 : err_sticky) | (conv_digit && sd_is_illegal(q_value));
  end

  // State register
  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: the upcoming digit index decides between skipping and converting
  always_comb begin
    state_nxt = state;
    if (accept) begin
      if (last_digit) begin
        state_nxt = IDLE;
      end else if (idx_inc >= OD_IDX) begin
        state_nxt = CONV;
      end else begin
        state_nxt = SKIP;
      end
    end
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state != IDLE);
  end

  // Accepted-digit counter, wraps to zero at the end of each operation
  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      idx <= '0;
    end else if (accept) begin
      idx <= last_digit ? '0 : idx_inc;
    end
  end

  // Illegal-digit flag for the operation in flight
  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      err_sticky <= 1'b0;
    end else if (accept) begin
      err_sticky <= err_nxt;
    end
  end

  // Capture the final Q and error flag; valid pulses for exactly one cycle
  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      result       <= '0;
      digit_err    <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= last_digit;
      if (last_digit) begin
        result    <= q_next;
        digit_err <= err_nxt;
      end
    end
  end

  otf_qqm_reg #(
    .W (OUT_W)
  ) u_qqm (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .init       (start),
    .shift      (conv_digit),
    .digit      (q_value),
    .q_next     (q_next)
  );

endmodule
